// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg
//   Shared constants, types and helpers for the round-robin arbitrating mux.
//   WORD_W     default data width
//   clog2      ceiling log2 of a positive integer
//   sel_width  channel-index width, at least one bit
//   lock_st_e  packet-lock state of the arbiter
package rr_arb_mux_pkg;

    localparam int WORD_W = 32;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int sel_width(input int channels);
        return (channels > 1) ? clog2(channels) : 1;
    endfunction

    // ST_OPEN: any valid channel may win. ST_LOCKED: only the locked channel may win.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_e;

endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if
//   Bundles the requester side and the consumer side of the arbitrating mux.
//   in_valid/in_ready/in_data/in_last   CHANNELS requesters (channel i at [i*WIDTH +: WIDTH])
//   out_valid/out_ready/out_data/out_sel/out_last   single registered consumer port
//   dbg_ptr/dbg_lock                    round-robin pointer and lock state, observation only
//
// Handshake: a beat moves across a port in the cycle where valid and ready are both high
// at the rising clock edge. A producer keeps valid (and its data) stable until accepted;
// in_ready is a combinational function of in_valid, out_ready and internal state.
//
// Modports: slave = the arbiter itself, master = the surrounding requesters and consumer.
interface rr_arb_mux_if
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH    = WORD_W,
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_width(CHANNELS)
);
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_sel;
    logic                      out_last;
    logic [SELW-1:0]           dbg_ptr;
    logic                      dbg_lock;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last, dbg_ptr, dbg_lock
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last, dbg_ptr, dbg_lock
    );
endinterface

// File: rtl/rr_arb_mux_pick.sv
// rr_arb_mux_pick
//   Combinational round-robin picker. Finds the first set bit of req starting at ptr+1
//   and wrapping modulo CHANNELS.
//   req      per-channel request
//   ptr      index of the most recent winner
//   gnt      one-hot grant (zero when nothing requests)
//   gnt_idx  binary index of the winner (zero when nothing requests)
//   any      at least one request present
module rr_arb_mux_pick
    import rr_arb_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [CHANNELS-1:0] gnt,
    output logic [SELW-1:0]     gnt_idx,
    output logic                any
);
    logic [SELW-1:0]       start;
    logic [2*CHANNELS-1:0] dreq;

    // Requests are laid out twice; masking the lower copy below `start` turns the
    // wrap-around search into a plain lowest-bit-first scan of the doubled vector.
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        dreq    = {req, req};
        // Explicit wrap compare so CHANNELS need not be a power of two.
        if (ptr == SELW'(CHANNELS - 1)) begin
            start = '0;
        end else begin
            start = ptr + SELW'(1);
        end
        for (int j = 0; j < 2 * CHANNELS; j++) begin
            if (!any && dreq[j] && (j >= int'(start))) begin
                any     = 1'b1;
                gnt_idx = (j >= CHANNELS) ? SELW'(j - CHANNELS) : SELW'(j);
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            gnt[i] = any && (gnt_idx == SELW'(i));
        end
    end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux
//   Registered N-channel multiplexer with round-robin arbitration. One valid requester
//   is granted per cycle, its beat is captured in the output register and held until
//   the consumer accepts it. With LOCK=1 a grant sticks to one channel until the beat
//   carrying in_last has been taken.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   requester and consumer signals (see rr_arb_mux_if)
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH    = WORD_W,
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_width(CHANNELS),
    parameter int LOCK     = 1
) (
    input  logic           clk,
    input  logic           rst,
    rr_arb_mux_if.slave    bus
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic             out_last_q,  out_last_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;
    lock_st_e         lock_q,      lock_d;
    logic [SELW-1:0]  lock_idx_q,  lock_idx_d;

    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] gnt;
    logic [SELW-1:0]     gnt_idx;
    logic                any;
    logic                load;
    logic                xfer;
    logic [WIDTH-1:0]    pick_data;
    logic                pick_last;

    // While locked, every channel except the lock owner is hidden from the picker.
    // If the owner drops valid nothing is granted and the lock simply persists.
    always_comb begin
        req = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            req[i] = bus.in_valid[i] &
                     ((lock_q == ST_OPEN) || (lock_idx_q == SELW'(i)));
        end
    end

    rr_arb_mux_pick #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .any      (any)
    );

    // The output register can take a new beat when empty or being drained this cycle.
    // rst gates the transfer so nothing is accepted while reset is asserted.
    assign load         = !out_valid_q || bus.out_ready;
    assign xfer         = load && any && !rst;
    assign bus.in_ready = xfer ? gnt : '0;

    // Data mux: constant part-selects compared against the grant index.
    always_comb begin
        pick_data = '0;
        pick_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_idx == SELW'(i)) begin
                pick_data = bus.in_data[i*WIDTH +: WIDTH];
                pick_last = bus.in_last[i];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_data;
            out_sel_d   = gnt_idx;
            out_last_d  = pick_last;
            // Pointer moves only on a real transfer so stalls keep the fairness order.
            ptr_d       = gnt_idx;
            if (LOCK != 0) begin
                lock_d     = pick_last ? ST_OPEN : ST_LOCKED;
                lock_idx_d = gnt_idx;
            end
        end else if (bus.out_ready) begin
            // Drained with nothing to replace it; data registers keep their stale value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
            ptr_q       <= SELW'(CHANNELS - 1);
            lock_q      <= ST_OPEN;
            lock_idx_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_last  = out_last_q;
    assign bus.dbg_ptr   = ptr_q;
    assign bus.dbg_lock  = (lock_q == ST_LOCKED);
endmodule
